// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding and word geometry.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_WIDTH     = 32;

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    // The byte link is open only while a stream is still being consumed.
    function automatic logic accepts_bytes(state_e s);
        return (s == S_COUNT) || (s == S_LOAD) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte link plus main-memory write port of the program loader.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    // Byte link: a byte moves on every rising edge where rx_valid && rx_ready;
    // rx_data is only meaningful while rx_valid is high, and the host may drop
    // rx_valid at any time. The memory port has no handshake: mem_we is a
    // one-cycle strobe that the memory must always take.
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader_byte_to_word.sv
// Assembles little-endian 32-bit words from accepted bytes; word_valid marks the 4th byte.
module byte_to_word
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_idx;
    logic [31:0] shift_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx <= 2'd0;
            shift_q  <= 32'd0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            shift_q  <= {byte_data, shift_q[31:8]};
        end
    end

    // The completed word is presented in the same cycle as its last byte.
    assign word       = {byte_data, shift_q[31:8]};
    assign word_valid = byte_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: COUNT, N payload words, CHECKSUM; writes memory and releases the core on a match.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    program_loader_if.slave        bus,
    output logic                   core_reset,
    output logic                   done,
    output logic                   error,
    output state_e                 dbg_state
);

    localparam int                    MAX_WORDS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [ADDR_WIDTH:0]     wcnt_q, wcnt_d;
    logic [CSUM_WIDTH-1:0]   acc_q, acc_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    ready_q, ready_d;
    logic                    core_reset_q, core_reset_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic        byte_fire;
    logic [31:0] word;
    logic        word_valid;

    assign byte_fire = bus.rx_valid && ready_q;

    byte_to_word u_b2w (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (byte_fire),
        .byte_data  (bus.rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_COUNT;
            count_q      <= '0;
            wcnt_q       <= '0;
            acc_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= BASE;
            wdata_q      <= 32'd0;
            ready_q      <= 1'b1;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wcnt_q       <= wcnt_d;
            acc_q        <= acc_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_COUNT: begin
                if (word_valid) begin
                    if (word > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else if (word == 32'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        count_d = word[ADDR_WIDTH:0];
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    we_d    = 1'b1;
                    addr_d  = BASE + wcnt_q[ADDR_WIDTH-1:0];
                    wdata_d = word;
                    acc_d   = acc_q + word;
                    wcnt_d  = wcnt_q + CNT_ONE;
                    if (wcnt_q == count_q - CNT_ONE) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (word_valid) begin
                    state_d = (word == acc_q) ? S_RUN : S_ERR;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Status flags are registered from the next state so they move on the deciding edge.
        ready_d      = accepts_bytes(state_d);
        core_reset_d = (state_d != S_RUN);
        done_d       = (state_d == S_RUN);
        error_d      = (state_d == S_ERR);
    end

    assign bus.rx_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign core_reset    = core_reset_q;
    assign done          = done_q;
    assign error         = error_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader against a stream-level reference model.
module tb_program_loader;
    import loader_pkg::*;

    localparam int AW   = 10;
    localparam int BASE = 0;
    localparam int MAXW = 1 << AW;

    logic   clock = 1'b0;
    logic   reset = 1'b1;
    logic   core_reset, done, error;
    state_e dbg_state;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [AW+31:0] exp_q[$];
    logic [7:0]     stream_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected (addr, data).
    always @(negedge clock) begin
        logic [AW+31:0] e;
        if (bus.mem_we === 1'b1) begin
            check("write_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", 64'(bus.mem_addr), 64'(e[AW+31:32]));
                check("write_data", 64'(bus.mem_wdata), 64'(e[31:0]));
            end
        end
    end

    // Reference model
    function automatic logic [31:0] word_at(input int i);
        logic [31:0] w;
        w = 32'd0;
        for (int b = 0; b < 4; b++) w = w + (32'(stream_q[i + b]) << (8 * b));
        return w;
    endfunction

    task automatic build_model(output bit exp_done, output bit exp_err, output int last_idx);
        logic [31:0] n, sum, w, cs;
        exp_q.delete();
        sum = 32'd0;
        n   = word_at(0);
        if (n > MAXW) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            last_idx = 3;
        end else begin
            for (int k = 0; k < int'(n); k++) begin
                w   = word_at(4 + 4 * k);
                sum = sum + w;
                exp_q.push_back({AW'(BASE + k), w});
            end
            cs       = word_at(4 + 4 * int'(n));
            exp_done = (cs == sum);
            exp_err  = !exp_done;
            last_idx = 4 * int'(n) + 7;
        end
    endtask

    // Driver tasks
    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) stream_q.push_back(8'((w >> (8 * b)) & 32'hff));
    endtask

    task automatic send_byte(input logic [7:0] b, output bit accepted);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        accepted     = bus.rx_ready;
        @(negedge clock);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic do_reset();
        exp_q.delete();
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(BASE));
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_COUNT));
        reset = 1'b0;
    endtask

    task automatic run_stream(input string name, input int gap_max, input bit toggle);
        bit ed, ee, acc;
        int last;
        build_model(ed, ee, last);
        for (int i = 0; i < stream_q.size(); i++) begin
            if (toggle) idle(1 + $urandom_range(0, gap_max));
            else if (gap_max > 0) idle($urandom_range(0, gap_max));
            send_byte(stream_q[i], acc);
            check({name, "_accept"}, 64'(acc), 64'(i <= last));
            if (i == last - 1) begin
                check({name, "_early_done"}, 64'(done), 64'd0);
                check({name, "_early_error"}, 64'(error), 64'd0);
                check({name, "_early_core_reset"}, 64'(core_reset), 64'd1);
            end
            if (i == last) begin
                check({name, "_done"}, 64'(done), 64'(ed));
                check({name, "_error"}, 64'(error), 64'(ee));
                check({name, "_core_reset"}, 64'(core_reset), 64'(!ed));
                check({name, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
            end
        end
        idle(3);
        check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_final_done"}, 64'(done), 64'(ed));
        check({name, "_final_error"}, 64'(error), 64'(ee));
    endtask

    task automatic nominal_stream(input logic [31:0] cs);
        stream_q.delete();
        push_word(32'd2);
        push_word(32'h0000_0013);
        push_word(32'h0010_0093);
        push_word(cs);
    endtask

    initial begin
        bit ed, ee, acc;
        int last, n;
        logic [31:0] w, sum;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        do_reset();

        nominal_stream(32'h0010_00A6);
        run_stream("nominal", 0, 1'b0);

        do_reset();
        nominal_stream(32'h0010_00A7);
        push_word(32'hDEAD_BEEF);
        run_stream("bad_csum", 0, 1'b0);

        do_reset();
        stream_q.delete();
        push_word(32'd0);
        push_word(32'd0);
        run_stream("empty", 0, 1'b0);

        do_reset();
        stream_q.delete();
        push_word(32'(MAXW + 1));
        push_word(32'h1234_5678);
        run_stream("oversize", 0, 1'b0);

        do_reset();
        nominal_stream(32'h0010_00A6);
        run_stream("throttled", 5, 1'b1);

        // Abort a load after six bytes, then replay the full stream.
        do_reset();
        nominal_stream(32'h0010_00A6);
        build_model(ed, ee, last);
        for (int i = 0; i < 6; i++) send_byte(stream_q[i], acc);
        do_reset();
        run_stream("reload", 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            do_reset();
            stream_q.delete();
            n = $urandom_range(1, 8);
            sum = 32'd0;
            push_word(32'(n));
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                sum = sum + w;
                push_word(w);
            end
            if ($urandom_range(0, 2) == 0) sum = sum ^ (32'd1 << $urandom_range(0, 31));
            push_word(sum);
            push_word($urandom);
            run_stream("random", 3, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
